// File: rtl/mul_div_unit_pkg.sv
// Shared MDU settings: operation encoding driven by the decode controller.
package mul_div_unit_pkg;

    typedef enum logic [3:0] {
        MDU_READ_HI            = 4'd0,
        MDU_READ_LO            = 4'd1,
        MDU_WRITE_HI           = 4'd2,
        MDU_WRITE_LO           = 4'd3,
        MDU_START_SIGNED_MUL   = 4'd4,
        MDU_START_UNSIGNED_MUL = 4'd5,
        MDU_START_SIGNED_DIV   = 4'd6,
        MDU_START_UNSIGNED_DIV = 4'd7
    } mdu_op_e;

endpackage

// File: rtl/mul_div_unit_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle, WIDTH cycles after go.
module mdu_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic             run;
    logic [WIDTH:0]   shifted, diff;

    assign shifted = {remainder, quotient[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    // high during the cycle whose edge retires the final quotient bit
    assign done    = run && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remainder <= '0;
            quotient  <= '0;
            dvs       <= '0;
            cnt       <= '0;
            run       <= 1'b0;
        end else if (go) begin
            remainder <= '0;
            quotient  <= dividend;
            dvs       <= divisor;
            cnt       <= '0;
            run       <= 1'b1;
        end else if (run) begin
            if (!diff[WIDTH]) begin
                remainder <= diff[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= shifted[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt + CW'(1);
            if (done) run <= 1'b0;
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit owning HI/LO; fixed-latency MULT, iterative DIV.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  mdu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(MUL_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a, op_b;
    logic             mul_sgn, neg_q, neg_r, div0;
    logic             accept, div_op, div_sgn, div_go, div_done;
    logic [WIDTH-1:0] dividend, divisor, quo, rem;
    logic [2*WIDTH-1:0] ext_a, ext_b, prod;

    assign busy    = (state != S_IDLE);
    assign accept  = start && !busy;
    assign div_sgn = (op == MDU_START_SIGNED_DIV);
    assign div_op  = div_sgn || (op == MDU_START_UNSIGNED_DIV);
    assign div_go  = accept && div_op;

    // magnitudes; -2^31 maps onto 2^31 which still fits unsigned
    assign dividend = (div_sgn && a[WIDTH-1]) ? -a : a;
    assign divisor  = (div_sgn && b[WIDTH-1]) ? -b : b;

    assign ext_a = mul_sgn ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    assign ext_b = mul_sgn ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    assign prod  = ext_a * ext_b;

    always_comb begin
        result = '0;
        if (start && !busy) begin
            if (op == MDU_READ_HI)      result = hi;
            else if (op == MDU_READ_LO) result = lo;
        end
    end

    mdu_divider #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (div_go),
        .dividend  (dividend),
        .divisor   (divisor),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hi      <= '0;
            lo      <= '0;
            op_a    <= '0;
            op_b    <= '0;
            mul_sgn <= 1'b0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            div0    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    case (op)
                        MDU_WRITE_HI: hi <= a;
                        MDU_WRITE_LO: lo <= a;
                        MDU_START_SIGNED_MUL, MDU_START_UNSIGNED_MUL: begin
                            op_a    <= a;
                            op_b    <= b;
                            mul_sgn <= (op == MDU_START_SIGNED_MUL);
                            cnt     <= CW'(1);
                            state   <= S_MUL;
                        end
                        MDU_START_SIGNED_DIV, MDU_START_UNSIGNED_DIV: begin
                            op_a  <= a;
                            neg_q <= div_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r <= div_sgn && a[WIDTH-1];
                            div0  <= (b == '0);
                            state <= S_DIV;
                        end
                        default: ;
                    endcase
                end
                S_MUL: begin
                    if (cnt == CW'(MUL_CYCLES)) begin
                        {hi, lo} <= prod;
                        cnt      <= '0;
                        state    <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DIV: if (div_done) state <= S_FIX;
                S_FIX: begin
                    // divide-by-zero bypasses sign fix-up: all-ones quotient, raw dividend
                    if (div0) begin
                        lo <= '1;
                        hi <= op_a;
                    end else begin
                        lo <= neg_q ? -quo : quo;
                        hi <= neg_r ? -rem : rem;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
